divider_nonrestoring: RTL and testbench

- Sequential radix-2 non-restoring integer divider, 16-bit by default. It is the inverse-operation companion to the radix-4 Booth multiplier in the ALU.
- Accepts dividend/divisor on a begin_signal handshake. Produces quotient and remainder. Pulses end_signal on completion.
- Sits beside the multiplier in the ALU datapath and uses the same begin/end handshake naming, so the same controller drives both.

---
 rtl/divider_nonrestoring.sv | 160 ++++++++++++++++
 tb/tb_divider_nonrestoring.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_nonrestoring.sv
// Sequential radix-2 non-restoring integer divider producing a truncating quotient and a dividend-signed remainder.
// Shares the begin/end handshake of the ALU multiplier so that one controller can drive both.
module divider_nonrestoring #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             begin_signal,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             end_signal,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     p_q, p_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               end_q, end_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH:0]     p_sh;
    logic [WIDTH:0]     p_new;
    logic [WIDTH:0]     r_fix;

    // Handshake: begin_signal is a request honoured only in IDLE (operands captured on that edge);
    // end_signal is a one-cycle completion pulse, and busy covers accept edge up to that pulse.
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        q_d        = q_q;
        bmag_d     = bmag_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dbz_pend_d = dbz_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        end_d      = 1'b0;
        dbz_d      = dbz_q;
        a_mag      = '0;
        p_sh       = '0;
        p_new      = '0;
        r_fix      = '0;

        case (state_q)
            S_IDLE: begin
                if (begin_signal) begin
                    busy_d = 1'b1;
                    if (b == '0) begin
                        quot_d     = '1;
                        rem_d      = a;
                        dbz_pend_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        a_mag      = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
                        bmag_d     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
                        q_d        = a_mag;
                        p_d        = '0;
                        cnt_d      = '0;
                        qneg_d     = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d     = is_signed && a[WIDTH-1];
                        dbz_pend_d = 1'b0;
                        state_d    = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // The sign of the previous partial remainder picks subtract or add-back.
                p_sh  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
                p_new = p_q[WIDTH] ? (p_sh + {1'b0, bmag_q}) : (p_sh - {1'b0, bmag_q});
                p_d   = p_new;
                q_d   = {q_q[WIDTH-2:0], ~p_new[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                r_fix   = p_q[WIDTH] ? (p_q + {1'b0, bmag_q}) : p_q;
                quot_d  = qneg_q ? (~q_q + 1'b1) : q_q;
                rem_d   = rneg_q ? (~r_fix[WIDTH-1:0] + 1'b1) : r_fix[WIDTH-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                end_d   = 1'b1;
                busy_d  = 1'b0;
                dbz_d   = dbz_pend_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            q_q        <= '0;
            bmag_q     <= '0;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            end_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            q_q        <= q_d;
            bmag_q     <= bmag_d;
            cnt_q      <= cnt_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            dbz_pend_q <= dbz_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            end_q      <= end_d;
            dbz_q      <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign end_signal  = end_q;
    assign div_by_zero = dbz_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_divider_nonrestoring.sv
// Bench for divider_nonrestoring: directed corner cases, protocol cases and a random regression
// compared against a truncating-division reference model.
module tb_divider_nonrestoring;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         begin_signal;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         end_signal;
    logic         div_by_zero;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    divider_nonrestoring #(.WIDTH(W), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .begin_signal (begin_signal),
        .is_signed    (is_signed),
        .a            (a),
        .b            (b),
        .quotient     (quotient),
        .remainder    (remainder),
        .busy         (busy),
        .end_signal   (end_signal),
        .div_by_zero  (div_by_zero),
        .state_dbg_o  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: truncating division, remainder takes the dividend's sign.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                  output logic [W-1:0] eq, output logic [W-1:0] er);
        int sa;
        int sb;
        if (mb == '0) begin
            eq = '1;
            er = ma;
        end else if (ms) begin
            sa = int'($signed(ma));
            sb = int'($signed(mb));
            eq = W'(sa / sb);
            er = W'(sa % sb);
        end else begin
            eq = ma / mb;
            er = ma % mb;
        end
    endfunction

    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_s,
                         input bit inject);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int lat;
        int exp_lat;
        model(op_a, op_b, op_s, eq, er);
        exp_q.push_back(eq);
        exp_q.push_back(er);
        exp_lat = (op_b == '0) ? 1 : W + 2;
        lat = 0;
        @(negedge clk);
        a = op_a;
        b = op_b;
        is_signed = op_s;
        begin_signal = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_accept", busy, 1'b1);
        check("end_after_accept", end_signal, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (inject && c == 5) begin
                begin_signal = 1'b1;
                a = 16'd9;
                b = 16'd3;
            end else begin
                begin_signal = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
                is_signed = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (end_signal) begin
                lat = c;
                break;
            end
        end
        begin_signal = 1'b0;
        check("latency", lat, exp_lat);
        check("busy_at_end", busy, 1'b0);
        check("quotient", quotient, exp_q.pop_front());
        check("remainder", remainder, exp_q.pop_front());
        check("div_by_zero", div_by_zero, (op_b == '0) ? 1'b1 : 1'b0);
    endtask

    initial begin
        int end_seen;
        int first_end;
        int second_end;
        int r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        rst = 1'b1;
        begin_signal = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_quotient", quotient, 16'h0);
        check("rst_remainder", remainder, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_end", end_signal, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        rst = 1'b0;

        do_op(16'd100, 16'd7, 1'b0, 1'b0);
        do_op(16'hFFF9, 16'd2, 1'b1, 1'b0);
        do_op(16'd7, 16'hFFFE, 1'b1, 1'b0);
        do_op(16'h1234, 16'h0, 1'b0, 1'b0);
        do_op(16'd100, 16'd7, 1'b0, 1'b0);
        do_op(16'h1234, 16'h0, 1'b1, 1'b0);
        do_op(16'h8000, 16'hFFFF, 1'b1, 1'b0);
        do_op(16'h8000, 16'hFFFF, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'd1, 1'b0, 1'b0);
        do_op(16'd3, 16'hFFFF, 1'b0, 1'b0);
        do_op(16'd50, 16'd5, 1'b0, 1'b1);

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 16'd50;
        b = 16'd5;
        is_signed = 1'b0;
        begin_signal = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            begin_signal = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort_quotient", quotient, 16'h0);
        check("abort_remainder", remainder, 16'h0);
        check("abort_busy", busy, 1'b0);
        check("abort_end", end_signal, 1'b0);
        check("abort_state", state_dbg, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        end_seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (end_signal) end_seen++;
        end
        check("abort_no_end", end_seen, 0);
        do_op(16'd9, 16'd3, 1'b0, 1'b0);

        // begin_signal held high across DONE -> IDLE restarts immediately.
        @(negedge clk);
        a = 16'd100;
        b = 16'd7;
        is_signed = 1'b0;
        begin_signal = 1'b1;
        @(posedge clk);
        first_end = 0;
        second_end = 0;
        for (int c = 1; c <= 37; c++) begin
            @(posedge clk);
            #1;
            if (end_signal) begin
                if (first_end == 0) first_end = c;
                else second_end = c;
            end
        end
        @(negedge clk);
        begin_signal = 1'b0;
        check("b2b_first_end", first_end, W + 2);
        check("b2b_second_end", second_end, 2 * W + 5);
        check("b2b_quotient", quotient, 16'd14);
        check("b2b_remainder", remainder, 16'd2);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            case (r)
                0: rb = '0;
                1: rb = '1;
                2: ra = 16'h8000;
                3: rb = W'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(ra, rb, rs, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
